// File: rtl/precise_counter_ctrl_pkg.sv
// Shared definitions for the PreciseCounter control path: state encodings and default count width.
package precise_counter_ctrl_pkg;

    localparam int PC_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_LAP  = 3'd2,
        ST_STOP = 3'd3,
        ST_DONE = 3'd4
    } pc_state_e;

endpackage

// File: rtl/pc_tick_gen.sv
// Prescaler for the count timebase: counts 0..DIV-1 while enabled, holds otherwise,
// exposes the terminal condition combinationally and a registered 1-cycle tick.
module pc_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic term_o,
    output logic tick_o
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q;

    assign term_o = en_i && (pre_q == LAST);
    assign tick_o = tick_q;

    // Holding the value while disabled keeps the fractional period across a stop.
    always_comb begin
        pre_d = pre_q;
        if (clr_i || term_o) pre_d = '0;
        else if (en_i)       pre_d = pre_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= term_o && !clr_i;
        end
    end

endmodule

// File: rtl/precise_counter_ctrl.sv
// Start/stop/lap/clear FSM and prescaled count feeding the display holder.
// Optional lap auto-release when LAP_TIMEOUT_EN is defined.
module precise_counter_ctrl
    import precise_counter_ctrl_pkg::*;
#(
    parameter int W         = PC_W,
    parameter int DIV       = 1000,
    parameter int MAX_COUNT = 2047
`ifdef LAP_TIMEOUT_EN
    , parameter int LAP_TICKS = 500
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_ss,
    input  logic         btn_lap,
    input  logic         btn_clr,
    output logic [W-1:0] count,
    output logic         tick,
    output logic         hold_pause,
    output logic         hold_rst,
    output logic         running,
    output logic         done
);
    localparam logic [W-1:0] MAXV = W'(MAX_COUNT);

    pc_state_e    state_q, state_d;
    logic [W-1:0] count_q, count_d, count_inc;
    logic         ss_q, lap_q, clr_q;
    logic         ss_p, lap_p, clr_p;
    logic         hold_pause_q, hold_rst_q;
    logic         en, term, at_max, lap_expire;

    assign ss_p  = btn_ss  & ~ss_q;
    assign lap_p = btn_lap & ~lap_q;
    assign clr_p = btn_clr & ~clr_q;

    assign en        = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign count_inc = count_q + 1'b1;
    assign at_max    = term && (count_inc == MAXV);

    pc_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .clr_i  (clr_p),
        .term_o (term),
        .tick_o (tick)
    );

`ifdef LAP_TIMEOUT_EN
    localparam int LW = $clog2(LAP_TICKS + 1);
    logic [LW-1:0] lap_ticks_q, lap_ticks_d;

    assign lap_expire = term && (lap_ticks_q == LW'(LAP_TICKS - 1));

    always_comb begin
        lap_ticks_d = lap_ticks_q;
        if (state_q != ST_LAP) lap_ticks_d = '0;
        else if (term)         lap_ticks_d = lap_ticks_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) lap_ticks_q <= '0;
        else     lap_ticks_q <= lap_ticks_d;
    end
`else
    assign lap_expire = 1'b0;
`endif

    // Reaching MAX_COUNT beats a same-edge stop; otherwise clr > ss > lap > timeout.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clr_p) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            if (term) count_d = count_inc;
            unique case (state_q)
                ST_IDLE: if (ss_p) state_d = ST_RUN;
                ST_RUN: begin
                    if (at_max)     state_d = ST_DONE;
                    else if (ss_p)  state_d = ST_STOP;
                    else if (lap_p) state_d = ST_LAP;
                end
                ST_LAP: begin
                    if (at_max)                  state_d = ST_DONE;
                    else if (ss_p)               state_d = ST_STOP;
                    else if (lap_p | lap_expire) state_d = ST_RUN;
                end
                ST_STOP: if (ss_p) state_d = ST_RUN;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            ss_q         <= 1'b0;
            lap_q        <= 1'b0;
            clr_q        <= 1'b0;
            hold_pause_q <= 1'b0;
            hold_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ss_q         <= btn_ss;
            lap_q        <= btn_lap;
            clr_q        <= btn_clr;
            hold_pause_q <= (state_q == ST_LAP);
            hold_rst_q   <= clr_p;
        end
    end

    assign count      = count_q;
    assign hold_pause = hold_pause_q;
    assign hold_rst   = hold_rst_q;
    assign running    = en;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_precise_counter_ctrl.sv
// Directed bench for precise_counter_ctrl (DIV=4, MAX_COUNT=10, LAP_TICKS=3).
module tb_precise_counter_ctrl;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
    logic [W-1:0] count;
    logic         tick, hold_pause, hold_rst, running, done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    precise_counter_ctrl #(
        .W(W), .DIV(4), .MAX_COUNT(10)
`ifdef LAP_TIMEOUT_EN
        , .LAP_TICKS(3)
`endif
    ) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .count(count), .tick(tick), .hold_pause(hold_pause), .hold_rst(hold_rst),
        .running(running), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_ss();
        btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    endtask

    initial begin
        logic seen;

        // reset
        cyc(2);
        chk("rst_count", 32'(count), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_pause", 32'(hold_pause), 0);
        chk("rst_hrst", 32'(hold_rst), 0);
        chk("rst_run", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;

        // start and tick cadence
        press_ss();
        chk("start_run", 32'(running), 1);
        cyc(3);
        chk("pre_tick_cnt", 32'(count), 0);
        chk("pre_tick", 32'(tick), 0);
        cyc(1);
        chk("tick1_cnt", 32'(count), 1);
        chk("tick1", 32'(tick), 1);
        cyc(1);
        chk("tick1_pulse", 32'(tick), 0);
        cyc(3);
        chk("tick2_cnt", 32'(count), 2);

        // stop with prescaler part-way, resume keeps the fraction
        cyc(4);
        chk("tick3_cnt", 32'(count), 3);
        cyc(1);
        press_ss();
        chk("stop_run", 32'(running), 0);
        cyc(20);
        chk("stop_cnt", 32'(count), 3);
        chk("stop_tick", 32'(tick), 0);
        press_ss();
        chk("resume_run", 32'(running), 1);
        cyc(1);
        chk("resume_r1_cnt", 32'(count), 3);
        cyc(1);
        chk("resume_r2_cnt", 32'(count), 4);
        chk("resume_r2_tick", 32'(tick), 1);

        // lap freeze and manual release
        cyc(4);
        chk("lap_pre_cnt", 32'(count), 5);
        press_lap();
        chk("lap_edge_pause", 32'(hold_pause), 0);
        chk("lap_edge_run", 32'(running), 1);
        cyc(1);
        chk("lap_pause", 32'(hold_pause), 1);
        cyc(2);
        chk("lap_cnt_rises", 32'(count), 6);
        chk("lap_pause_held", 32'(hold_pause), 1);
        press_lap();
        cyc(1);
        chk("lap_release", 32'(hold_pause), 0);

        // run to terminal count
        cyc(14);
        chk("max_cnt", 32'(count), 10);
        chk("max_done", 32'(done), 1);
        chk("max_run", 32'(running), 0);
        chk("max_tick", 32'(tick), 1);
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            seen = seen | tick;
        end
        chk("done_no_tick", 32'(seen), 0);
        chk("done_cnt_hold", 32'(count), 10);
        press_ss();
        chk("done_ss_ign", 32'(done), 1);
        press_lap();
        chk("done_lap_ign", 32'(done), 1);
        chk("done_lap_pause", 32'(hold_pause), 0);
        cyc(2);
        btn_clr = 1'b1; cyc(1); btn_clr = 1'b0;
        chk("clr_hrst", 32'(hold_rst), 1);
        chk("clr_cnt", 32'(count), 0);
        chk("clr_done", 32'(done), 0);
        chk("clr_run", 32'(running), 0);
        cyc(1);
        chk("clr_hrst_pulse", 32'(hold_rst), 0);

        // clr + ss + lap together while running
        press_ss();
        cyc(5);
        chk("multi_pre_cnt", 32'(count), 1);
        btn_clr = 1'b1; btn_ss = 1'b1; btn_lap = 1'b1;
        cyc(1);
        btn_clr = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0;
        chk("multi_run", 32'(running), 0);
        chk("multi_cnt", 32'(count), 0);
        chk("multi_pause", 32'(hold_pause), 0);
        chk("multi_hrst", 32'(hold_rst), 1);
        cyc(1);

        // held ss level is a single press; then lap timeout behaviour
        btn_ss = 1'b1; cyc(3); btn_ss = 1'b0;
        chk("held_ss_run", 32'(running), 1);
        cyc(6);
        chk("to_pre_cnt", 32'(count), 2);
        press_lap();
        cyc(1);
        chk("to_pause", 32'(hold_pause), 1);
        cyc(10);
        chk("to_cnt", 32'(count), 5);
        chk("to_pause_held", 32'(hold_pause), 1);
        cyc(1);
`ifdef LAP_TIMEOUT_EN
        chk("to_release", 32'(hold_pause), 0);
`else
        chk("to_no_release", 32'(hold_pause), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
